// File: rtl/pipe_mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The stage is the master: it drives the request, the data memory answers with
// a one-cycle acknowledge and, for loads, the read word.
interface pipe_mem_stage_if;
  logic        Mem_Req;
  logic        Mem_We;
  logic [29:0] Mem_Addr;
  logic [3:0]  Mem_Be;
  logic [31:0] Mem_Wdata;
  logic        Mem_Ack;
  logic [31:0] Mem_Rdata;

  modport master (
    output Mem_Req,
    output Mem_We,
    output Mem_Addr,
    output Mem_Be,
    output Mem_Wdata,
    input  Mem_Ack,
    input  Mem_Rdata
  );

  modport slave (
    input  Mem_Req,
    input  Mem_We,
    input  Mem_Addr,
    input  Mem_Be,
    input  Mem_Wdata,
    output Mem_Ack,
    output Mem_Rdata
  );
endinterface

// File: rtl/pipe_mem_stage.sv
// MEM stage of the 5-stage pipeline: issues loads/stores on the data-memory
// bus, steers byte/half/word lanes, extends load data, and stalls the front of
// the pipe while an access is outstanding. Feeds the MEM/WB register inputs.
module pipe_mem_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   M_Wreg,
  input  logic                   M_Reg2reg,
  input  logic                   M_Rmem,
  input  logic                   M_Wmem,
  input  logic [1:0]             M_Size,
  input  logic                   M_Sext,
  input  logic [31:0]            M_ALUR,
  input  logic [31:0]            M_Data,
  input  logic [4:0]             M_Rd,
  pipe_mem_stage_if.master       bus,
  output logic                   O_Wreg,
  output logic                   O_Reg2reg,
  output logic [31:0]            O_ALUR,
  output logic [31:0]            O_Dout,
  output logic [4:0]             O_Rd,
  output logic                   M_Stall,
  output logic                   M_AdErr,
  output logic                   M_BusErr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt;
  logic             r_buserr;
  logic [31:0]      r_dout;
  logic [1:0]       r_lane;
  logic [1:0]       r_size;
  logic             r_sext;

  logic             w_mem_op;
  logic             w_aderr;
  logic             w_access;
  logic             w_start;
  logic             w_ack;
  logic             w_timeout;
  logic             w_stall;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load_fmt;

  // Alignment check and access qualification from the EX/MEM operands
  always_comb begin
    w_mem_op = M_Rmem | M_Wmem;
    w_aderr  = w_mem_op &
               (((M_Size == 2'b01) & M_ALUR[0]) |
                (M_Size[1] & (M_ALUR[1:0] != 2'b00)));
    w_access = w_mem_op & ~w_aderr;
    w_start  = (r_state == S_IDLE) & w_access;
    // An ack outside BUSY never completes anything.
    w_ack     = (r_state == S_BUSY) & bus.Mem_Ack;
    // Ack in the last allowed cycle wins over the timeout.
    w_timeout = (r_state == S_BUSY) & ~bus.Mem_Ack &
                (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Store lane steering: byte enables and replicated write data
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = M_Data;
    case (M_Size)
      2'b00: begin
        w_be    = 4'b0001 << M_ALUR[1:0];
        w_wdata = {4{M_Data[7:0]}};
      end
      2'b01: begin
        w_be    = M_ALUR[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{M_Data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = M_Data;
      end
    endcase
  end

  // Load lane selection and extension, using the attributes latched at issue
  always_comb begin
    w_byte = bus.Mem_Rdata[7:0];
    case (r_lane)
      2'd0:    w_byte = bus.Mem_Rdata[7:0];
      2'd1:    w_byte = bus.Mem_Rdata[15:8];
      2'd2:    w_byte = bus.Mem_Rdata[23:16];
      default: w_byte = bus.Mem_Rdata[31:24];
    endcase
    w_half = r_lane[1] ? bus.Mem_Rdata[31:16] : bus.Mem_Rdata[15:0];
    case (r_size)
      2'b00:   w_load_fmt = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load_fmt = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load_fmt = bus.Mem_Rdata;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and stall decode
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_access;
        if (w_access) begin
          w_next = S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (w_ack || w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_stall = 1'b0;
        w_next  = S_IDLE;
      end
      default: begin
        w_stall = 1'b0;
        w_next  = S_IDLE;
      end
    endcase
  end

  // Bus request registers: loaded on issue, request dropped on ack or timeout
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.Mem_Req   <= 1'b0;
      bus.Mem_We    <= 1'b0;
      bus.Mem_Addr  <= '0;
      bus.Mem_Be    <= '0;
      bus.Mem_Wdata <= '0;
    end else if (w_start) begin
      bus.Mem_Req   <= 1'b1;
      bus.Mem_We    <= M_Wmem;
      bus.Mem_Addr  <= M_ALUR[31:2];
      bus.Mem_Be    <= w_be;
      bus.Mem_Wdata <= w_wdata;
    end else if (w_ack || w_timeout) begin
      bus.Mem_Req   <= 1'b0;
    end
  end

  // Timeout counter: counts BUSY cycles since issue
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Load attributes latched at issue so formatting does not depend on the held inputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_lane <= '0;
      r_size <= '0;
      r_sext <= 1'b0;
    end else if (w_start) begin
      r_lane <= M_ALUR[1:0];
      r_size <= M_Size;
      r_sext <= M_Sext;
    end
  end

  // Completion capture: formatted read data on ack, bus-error pulse on timeout
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_dout   <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= w_timeout;
      if (w_ack) begin
        r_dout <= w_load_fmt;
      end else if (w_timeout) begin
        r_dout <= '0;
      end
    end
  end

  // MEM/WB feed; r_buserr is only ever high in the DONE cycle after a timeout
  always_comb begin
    M_Stall   = w_stall;
    M_AdErr   = w_aderr;
    M_BusErr  = r_buserr;
    O_Wreg    = M_Wreg & ~w_stall & ~w_aderr &
                ~((r_state == S_DONE) & r_buserr);
    O_Reg2reg = M_Reg2reg;
    O_ALUR    = M_ALUR;
    O_Rd      = M_Rd;
    O_Dout    = (r_state == S_DONE) ? r_dout : '0;
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage: an EX/MEM driver that holds each instruction until
// the stage lets it retire, a data-memory responder with programmable ack delay
// and stray acks, and two scoreboard monitors (retirement side and bus side).
module tb_pipe_mem_stage;
  localparam int TO = 16;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        M_Wreg, M_Reg2reg, M_Rmem, M_Wmem, M_Sext;
  logic [1:0]  M_Size;
  logic [31:0] M_ALUR, M_Data;
  logic [4:0]  M_Rd;
  logic        O_Wreg, O_Reg2reg, M_Stall, M_AdErr, M_BusErr;
  logic [31:0] O_ALUR, O_Dout;
  logic [4:0]  O_Rd;

  pipe_mem_stage_if bus();

  pipe_mem_stage #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .Clk(Clk), .Rst(Rst),
    .M_Wreg(M_Wreg), .M_Reg2reg(M_Reg2reg), .M_Rmem(M_Rmem), .M_Wmem(M_Wmem),
    .M_Size(M_Size), .M_Sext(M_Sext), .M_ALUR(M_ALUR), .M_Data(M_Data), .M_Rd(M_Rd),
    .bus(bus),
    .O_Wreg(O_Wreg), .O_Reg2reg(O_Reg2reg), .O_ALUR(O_ALUR), .O_Dout(O_Dout), .O_Rd(O_Rd),
    .M_Stall(M_Stall), .M_AdErr(M_AdErr), .M_BusErr(M_BusErr)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        wreg;
    logic        r2r;
    logic [31:0] alur;
    logic [4:0]  rd;
    logic        aderr;
    logic        buserr;
    logic        chk_dout;
    logic [31:0] dout;
    int          stalls;
  } ret_t;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } busx_t;

  ret_t        ret_q[$];
  busx_t       bus_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          sb_en = 1'b0;
  bit          force_ack = 1'b0;
  bit          stray_en = 1'b0;
  int          cur_delay = 0;
  logic [31:0] cur_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Reference load formatting, straight from the lane/extension rules
  function automatic logic [31:0] fmt_load(input logic [31:0] rd, input logic [1:0] size,
                                           input logic sext, input logic [31:0] a);
    logic [31:0] v;
    if (size == 2'b00) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'b01) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Present one instruction, predict its effects, and hold it until it retires
  task automatic issue(input logic wreg, input logic r2r, input logic rmem, input logic wmem,
                       input logic [1:0] size, input logic sext, input logic [31:0] alur,
                       input logic [31:0] data, input logic [4:0] rd, input int delay,
                       input logic [31:0] rdata);
    ret_t  r;
    busx_t b;
    bit    mem, mis, acc, tmo, st;
    int    n;
    mem = rmem | wmem;
    mis = mem && ((size == 2'b01 && (alur % 2) != 0) || (size >= 2'b10 && (alur % 4) != 0));
    acc = mem && !mis;
    tmo = acc && (delay >= TO);
    r.wreg     = wreg && !mis && !tmo;
    r.r2r      = r2r;
    r.alur     = alur;
    r.rd       = rd;
    r.aderr    = mis;
    r.buserr   = tmo;
    r.chk_dout = !mem || (rmem && !wmem && acc && !tmo);
    r.dout     = mem ? fmt_load(rdata, size, sext, alur) : 32'h0;
    r.stalls   = !acc ? 0 : (tmo ? TO + 1 : delay + 2);
    if (acc) begin
      b.we   = wmem;
      b.addr = 30'(alur / 4);
      if (size == 2'b00) begin
        b.be    = 4'(32'd1 << (alur % 4));
        b.wdata = (data & 32'hFF) * 32'h0101_0101;
      end else if (size == 2'b01) begin
        b.be    = 4'(32'd3 << (alur % 4));
        b.wdata = (data & 32'hFFFF) * 32'h0001_0001;
      end else begin
        b.be    = 4'hF;
        b.wdata = data;
      end
      bus_q.push_back(b);
    end
    ret_q.push_back(r);
    M_Wreg = wreg; M_Reg2reg = r2r; M_Rmem = rmem; M_Wmem = wmem;
    M_Size = size; M_Sext = sext; M_ALUR = alur; M_Data = data; M_Rd = rd;
    cur_delay = delay;
    cur_rdata = rdata;
    sb_en = 1'b1;
    n = 0;
    do begin
      @(negedge Clk);
      st = M_Stall;
      n++;
    end while (st && n < 64);
    if (st) begin
      checks++;
      errors++;
      $display("FAIL retire_wait: got stall after %0d cycles expected retire", n);
      finish_run();
    end
    @(posedge Clk);
    #1;
  endtask

  // Data-memory responder: acks after the programmed delay, optional stray acks when idle
  int bcnt = 0;
  always @(negedge Clk) begin
    if (bus.Mem_Req) begin
      bus.Mem_Ack   = (bcnt == cur_delay) || force_ack;
      bus.Mem_Rdata = (bcnt == cur_delay) ? cur_rdata : $urandom();
      bcnt++;
    end else begin
      bcnt = 0;
      bus.Mem_Ack   = force_ack || (stray_en && $urandom_range(0, 3) == 0);
      bus.Mem_Rdata = $urandom();
    end
  end

  // Retirement monitor: an instruction leaves whenever the stage is not stalling
  int   stall_cnt = 0;
  ret_t m_r;
  always @(negedge Clk) begin
    if (sb_en && !Rst) begin
      if (M_Stall) begin
        stall_cnt++;
      end else begin
        if (ret_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL retire_unexpected: got retirement expected none");
        end else begin
          m_r = ret_q.pop_front();
          chk("o_wreg", O_Wreg, m_r.wreg);
          chk("o_reg2reg", O_Reg2reg, m_r.r2r);
          chk("o_alur", O_ALUR, m_r.alur);
          chk("o_rd", O_Rd, m_r.rd);
          chk("aderr", M_AdErr, m_r.aderr);
          chk("buserr", M_BusErr, m_r.buserr);
          chk("stall_cycles", 32'(stall_cnt), 32'(m_r.stalls));
          chk("req_at_retire", bus.Mem_Req, 1'b0);
          if (m_r.chk_dout) chk("o_dout", O_Dout, m_r.dout);
        end
        stall_cnt = 0;
      end
    end
  end

  // Bus monitor: checks each issued request and that it holds steady until dropped
  logic  prev_req = 1'b0;
  busx_t snap, b_exp;
  bit    unstable = 1'b0;
  always @(negedge Clk) begin
    if (sb_en && !Rst) begin
      if (bus.Mem_Req && !prev_req) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got request addr 0x%0h expected none", bus.Mem_Addr);
        end else begin
          b_exp = bus_q.pop_front();
          chk("mem_we", bus.Mem_We, b_exp.we);
          chk("mem_addr", bus.Mem_Addr, b_exp.addr);
          chk("mem_be", bus.Mem_Be, b_exp.be);
          chk("mem_wdata", bus.Mem_Wdata, b_exp.wdata);
        end
        snap.we = bus.Mem_We; snap.addr = bus.Mem_Addr;
        snap.be = bus.Mem_Be; snap.wdata = bus.Mem_Wdata;
        unstable = 1'b0;
      end else if (bus.Mem_Req) begin
        if (bus.Mem_We !== snap.we || bus.Mem_Addr !== snap.addr ||
            bus.Mem_Be !== snap.be || bus.Mem_Wdata !== snap.wdata) unstable = 1'b1;
      end else if (prev_req) begin
        chk("bus_stable", 32'(unstable), 32'h0);
      end
    end
    prev_req = bus.Mem_Req;
  end

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          kind, pick, d;
    Rst = 1'b1;
    M_Wreg = 0; M_Reg2reg = 0; M_Rmem = 0; M_Wmem = 0; M_Size = 0; M_Sext = 0;
    M_ALUR = 0; M_Data = 0; M_Rd = 0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_req", bus.Mem_Req, 1'b0);
    chk("rst_we", bus.Mem_We, 1'b0);
    chk("rst_addr", bus.Mem_Addr, 30'h0);
    chk("rst_be", bus.Mem_Be, 4'h0);
    chk("rst_wdata", bus.Mem_Wdata, 32'h0);
    chk("rst_buserr", M_BusErr, 1'b0);
    chk("rst_stall", M_Stall, 1'b0);
    chk("rst_dout", O_Dout, 32'h0);
    @(posedge Clk);
    #1 Rst = 1'b0;

    issue(1, 0, 1, 0, 2'b10, 0, 32'h0000_0100, 32'h0, 5'd3, 0, 32'hDEAD_BEEF);
    issue(1, 0, 1, 0, 2'b00, 1, 32'h0000_0103, 32'h0, 5'd4, 1, 32'h80FF_FFFF);
    issue(1, 0, 1, 0, 2'b00, 0, 32'h0000_0103, 32'h0, 5'd5, 2, 32'h80FF_FFFF);
    issue(0, 0, 0, 1, 2'b01, 0, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 0, 32'h0);
    issue(1, 0, 1, 0, 2'b10, 0, 32'h0000_0101, 32'h0, 5'd6, 0, 32'h0);
    issue(1, 1, 0, 0, 2'b10, 0, 32'hCAFE_0001, 32'h0, 5'd7, 0, 32'h0);
    issue(1, 0, 1, 0, 2'b10, 0, 32'h0000_0400, 32'h0, 5'd8, 40, 32'h1111_2222);
    issue(1, 0, 1, 0, 2'b01, 1, 32'h0000_0406, 32'h0, 5'd9, TO - 1, 32'h8001_7FFF);
    issue(1, 1, 0, 0, 2'b00, 0, 32'h0000_0010, 32'h0, 5'd10, 0, 32'h0);

    stray_en = 1'b1;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      a    = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      pick = $urandom_range(0, 9);
      d = (pick < 7) ? $urandom_range(0, 4) : ((pick < 9) ? $urandom_range(5, TO - 1) : TO + 4);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)), a, $urandom(),
            5'($urandom_range(0, 31)), d, $urandom());
    end
    stray_en = 1'b0;

    // Reset in the middle of an outstanding load, then a stray ack
    sb_en = 1'b0;
    M_Wreg = 1; M_Reg2reg = 0; M_Rmem = 1; M_Wmem = 0; M_Size = 2'b10;
    M_ALUR = 32'h0000_0300; M_Rd = 5'd11;
    cur_delay = 1000;
    repeat (4) @(negedge Clk);
    chk("midrst_req_before", bus.Mem_Req, 1'b1);
    chk("midrst_stall_before", M_Stall, 1'b1);
    @(posedge Clk);
    #1 Rst = 1'b1; M_Rmem = 0;
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    chk("midrst_req_after", bus.Mem_Req, 1'b0);
    chk("midrst_stall_after", M_Stall, 1'b0);
    chk("midrst_be_after", bus.Mem_Be, 4'h0);
    force_ack = 1'b1;
    @(negedge Clk);
    #1 force_ack = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("stray_req", bus.Mem_Req, 1'b0);
    chk("stray_stall", M_Stall, 1'b0);
    chk("stray_buserr", M_BusErr, 1'b0);
    chk("stray_dout", O_Dout, 32'h0);
    chk("stray_wreg", O_Wreg, 1'b1);
    chk("leftover_ret_q", 32'(ret_q.size()), 32'h0);
    chk("leftover_bus_q", 32'(bus_q.size()), 32'h0);
    finish_run();
  end

  initial begin
    #2_000_000;
    checks++;
    errors++;
    $display("FAIL global_timeout: got no completion expected finish");
    finish_run();
  end

endmodule
